// File: rtl/mux_arb.sv
// Packet-level round-robin arbiter for a 2-to-1 router output mux.
// It locks the mux onto one input from HEAD to TAIL, hands over at the tail with no bubble,
// and uses a watchdog to release a packet that stalls.
module mux_arb #(
  parameter int               TYPEW     = 2,
  parameter logic [TYPEW-1:0] TYPE_NONE = 2'b00,
  parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
  parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b10,
  parameter logic [TYPEW-1:0] TYPE_DATA = 2'b11,
  parameter int               TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  output logic [1:0]       sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             busy,
  output logic             err,
  output logic             err_port
);

  // State encodings equal the one-hot mux select they drive.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] wd_q, wd_d;
  logic       err_d;
  logic       err_port_d;

  logic head_0, tail_0, head_1, tail_1;
  logic req_0, req_1, any_req, winner;
  logic own_port, own_valid, own_tail;

  // DATA and NONE carry no meaning for arbitration; a HEAD on the locked input is just payload.
  always_comb begin
    head_0 = 1'b0;
    tail_0 = 1'b0;
    case (itype_0)
      TYPE_HEAD:            head_0 = 1'b1;
      TYPE_TAIL:            tail_0 = 1'b1;
      TYPE_DATA, TYPE_NONE: head_0 = 1'b0;
      default:              head_0 = 1'b0;
    endcase
  end

  always_comb begin
    head_1 = 1'b0;
    tail_1 = 1'b0;
    case (itype_1)
      TYPE_HEAD:            head_1 = 1'b1;
      TYPE_TAIL:            tail_1 = 1'b1;
      TYPE_DATA, TYPE_NONE: head_1 = 1'b0;
      default:              head_1 = 1'b0;
    endcase
  end

  always_comb begin
    req_0     = ivalid_0 & head_0;
    req_1     = ivalid_1 & head_1;
    any_req   = req_0 | req_1;
    winner    = (req_0 & req_1) ? ptr_q : req_1;
    own_port  = (state_q == LOCK1);
    own_valid = own_port ? ivalid_1 : ivalid_0;
    own_tail  = own_valid & (own_port ? tail_1 : tail_0);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      wd_q     <= 8'd0;
      err      <= 1'b0;
      err_port <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      err      <= err_d;
      err_port <= err_port_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    err_d      = 1'b0;
    err_port_d = err_port;
    case (state_q)
      IDLE: begin
        wd_d = 8'd0;
        if (any_req) begin
          state_d = winner ? LOCK1 : LOCK0;
          ptr_d   = ~winner;
        end
      end
      LOCK0, LOCK1: begin
        if (own_valid) begin
          wd_d = 8'd0;
          // Re-arbitrating on the tail edge is what gives back-to-back packets no bubble.
          if (own_tail) begin
            if (any_req) begin
              state_d = winner ? LOCK1 : LOCK0;
              ptr_d   = ~winner;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (wd_q == WD_LAST) begin
          state_d    = IDLE;
          wd_d       = 8'd0;
          err_d      = 1'b1;
          err_port_d = own_port;
          ptr_d      = ~own_port;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wd_d    = 8'd0;
      end
    endcase
  end

  always_comb begin
    sel     = state_q;
    grant_0 = (state_q == LOCK0);
    grant_1 = (state_q == LOCK1);
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mux_arb.sv
// Directed self-checking bench for mux_arb: round-robin handover, gapped packets,
// watchdog release, non-head flits in IDLE and asynchronous reset mid-packet.
module tb_mux_arb;

  localparam logic [1:0] TY_NONE = 2'b00;
  localparam logic [1:0] TY_HEAD = 2'b01;
  localparam logic [1:0] TY_TAIL = 2'b10;
  localparam logic [1:0] TY_DATA = 2'b11;

  logic       clk = 1'b0;
  logic       rst_;
  logic       ivalid_0, ivalid_1;
  logic [1:0] itype_0, itype_1;
  logic [1:0] sel;
  logic       grant_0, grant_1, busy, err, err_port;

  int tests = 0;
  int fails = 0;

  mux_arb #(
    .TYPEW(2), .TYPE_NONE(TY_NONE), .TYPE_HEAD(TY_HEAD),
    .TYPE_TAIL(TY_TAIL), .TYPE_DATA(TY_DATA), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1),
    .busy(busy), .err(err), .err_port(err_port)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_sel, input logic exp_err);
    check($sformatf("%s.sel", tag), 8'(sel), 8'(exp_sel));
    check($sformatf("%s.grant_0", tag), 8'(grant_0), 8'(exp_sel[0]));
    check($sformatf("%s.grant_1", tag), 8'(grant_1), 8'(exp_sel[1]));
    check($sformatf("%s.busy", tag), 8'(busy), 8'(|exp_sel));
    check($sformatf("%s.err", tag), 8'(err), 8'(exp_err));
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] t0,
                               input logic v1, input logic [1:0] t1);
    ivalid_0 = v0;
    itype_0  = t0;
    ivalid_1 = v1;
    itype_1  = t1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_ = 1'b0;
    applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
    @(negedge clk);
    rst_ = 1'b1;
    tick();
  endtask

  // Sends an n-flit packet (held HEAD, DATA..., TAIL) on one input, other input held constant.
  task automatic runPacket(input string tag, input bit port, input int n, input logic ov,
                           input logic [1:0] ot, input logic [1:0] exp_sel);
    logic [1:0] ty;
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s[%0d]", tag, k), exp_sel, 1'b0);
      ty = (k == 0) ? TY_HEAD : ((k == n - 1) ? TY_TAIL : TY_DATA);
      if (port == 1'b0) applyStimulus(1'b1, ty, ov, ot);
      else              applyStimulus(ov, ot, 1'b1, ty);
      tick();
    end
  endtask

  initial begin
    rst_ = 1'b0;
    applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
    #3;
    checkOutput("reset", 2'b00, 1'b0);
    check("reset.err_port", 8'(err_port), 8'd0);
    @(negedge clk);
    rst_ = 1'b1;
    tick();

    // Single requester: 22-flit packet on input 1.
    applyStimulus(1'b0, TY_NONE, 1'b1, TY_HEAD);
    tick();
    runPacket("single", 1'b1, 22, 1'b0, TY_NONE, 2'b10);
    applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
    checkOutput("single.after_tail", 2'b00, 1'b0);
    tick();
    checkOutput("single.idle", 2'b00, 1'b0);

    // Simultaneous heads after reset, bubble-free handovers, then alternating rounds.
    resetDut();
    applyStimulus(1'b1, TY_HEAD, 1'b1, TY_HEAD);
    tick();
    runPacket("rr.a0", 1'b0, 3, 1'b1, TY_HEAD, 2'b01);
    runPacket("rr.a1", 1'b1, 3, 1'b1, TY_HEAD, 2'b10);
    runPacket("rr.a2", 1'b0, 3, 1'b0, TY_NONE, 2'b01);
    applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
    checkOutput("rr.idle1", 2'b00, 1'b0);
    applyStimulus(1'b1, TY_HEAD, 1'b1, TY_HEAD);
    tick();
    runPacket("rr.b1", 1'b1, 3, 1'b0, TY_NONE, 2'b10);
    checkOutput("rr.idle2", 2'b00, 1'b0);
    applyStimulus(1'b1, TY_HEAD, 1'b1, TY_HEAD);
    tick();
    runPacket("rr.c0", 1'b0, 3, 1'b0, TY_NONE, 2'b01);
    checkOutput("rr.idle3", 2'b00, 1'b0);

    // Gapped packet on input 0: idle gaps of 7 stay below the watchdog limit.
    applyStimulus(1'b1, TY_HEAD, 1'b0, TY_NONE);
    tick();
    checkOutput("gap.head", 2'b01, 1'b0);
    applyStimulus(1'b1, TY_HEAD, 1'b0, TY_NONE);
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 2; j++) begin
        checkOutput($sformatf("gap.data%0d_%0d", r, j), 2'b01, 1'b0);
        applyStimulus(1'b1, TY_DATA, 1'b0, TY_NONE);
        tick();
      end
      for (int j = 0; j < 7; j++) begin
        checkOutput($sformatf("gap.idle%0d_%0d", r, j), 2'b01, 1'b0);
        applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
        tick();
      end
    end
    checkOutput("gap.pretail", 2'b01, 1'b0);
    applyStimulus(1'b1, TY_TAIL, 1'b0, TY_NONE);
    tick();
    applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
    checkOutput("gap.release", 2'b00, 1'b0);

    // Stall on input 1: the 16th idle cycle is the last locked one.
    applyStimulus(1'b0, TY_NONE, 1'b1, TY_HEAD);
    tick();
    checkOutput("stall.lock", 2'b10, 1'b0);
    applyStimulus(1'b0, TY_NONE, 1'b1, TY_HEAD);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("stall.idle%0d", i), 2'b10, 1'b0);
      applyStimulus(1'b0, TY_NONE, 1'b0, TY_NONE);
      tick();
    end
    checkOutput("stall.release", 2'b00, 1'b1);
    check("stall.err_port", 8'(err_port), 8'd1);
    applyStimulus(1'b1, TY_HEAD, 1'b1, TY_HEAD);
    tick();
    checkOutput("stall.next", 2'b01, 1'b0);
    check("stall.err_port_hold", 8'(err_port), 8'd1);
    runPacket("stall.pkt0", 1'b0, 2, 1'b0, TY_NONE, 2'b01);
    checkOutput("stall.done", 2'b00, 1'b0);

    // Non-head flits in IDLE are ignored.
    applyStimulus(1'b1, TY_DATA, 1'b1, TY_TAIL);
    tick();
    checkOutput("nohead.a", 2'b00, 1'b0);
    applyStimulus(1'b1, TY_TAIL, 1'b1, TY_DATA);
    tick();
    checkOutput("nohead.b", 2'b00, 1'b0);
    applyStimulus(1'b1, TY_NONE, 1'b1, TY_NONE);
    tick();
    checkOutput("nohead.c", 2'b00, 1'b0);
    applyStimulus(1'b0, TY_NONE, 1'b1, TY_HEAD);
    tick();
    runPacket("nohead.pkt1", 1'b1, 2, 1'b0, TY_NONE, 2'b10);
    checkOutput("nohead.done", 2'b00, 1'b0);

    // Asynchronous reset during the 10th flit of an input 0 packet.
    applyStimulus(1'b1, TY_HEAD, 1'b0, TY_NONE);
    tick();
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("rst.flit%0d", k), 2'b01, 1'b0);
      applyStimulus(1'b1, (k == 0) ? TY_HEAD : TY_DATA, 1'b0, TY_NONE);
      tick();
    end
    checkOutput("rst.flit9", 2'b01, 1'b0);
    applyStimulus(1'b1, TY_DATA, 1'b0, TY_NONE);
    #4;
    rst_ = 1'b0;
    #2;
    checkOutput("rst.async", 2'b00, 1'b0);
    check("rst.err_port", 8'(err_port), 8'd0);
    @(negedge clk);
    rst_ = 1'b1;
    applyStimulus(1'b0, TY_NONE, 1'b1, TY_HEAD);
    tick();
    checkOutput("rst.relock", 2'b10, 1'b0);
    runPacket("rst.pkt1", 1'b1, 2, 1'b0, TY_NONE, 2'b10);
    checkOutput("rst.done", 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
